idu_issue_ctrl: RTL and testbench

//  Issue controller for the decode stage. It sits between IFU and EXU and sequences one held

---
 rtl/idu_issue_pkg.sv | 17 +
 rtl/idu_issue_ctrl_if.sv | 31 +++
 rtl/idu_scoreboard.sv | 44 ++++
 rtl/idu_issue_ctrl.sv | 69 ++++++
 tb/tb_idu_issue_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/idu_issue_pkg.sv
// idu_issue_pkg: shared types and default widths for the decode-stage issue controller.
package idu_issue_pkg;
  localparam int NREG_D = 32;
  localparam int CNT_W_D = 2;
  localparam int INFL_W_D = 3;
  typedef enum logic {EMPTY, HELD} state_e;
  typedef enum logic [1:0] {SC_NONE, SC_RAW, SC_SERIAL, SC_CAP} stall_e;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;
    logic       gpr_wen;
    logic       serial;
  } instr_t;
endpackage

// File: rtl/idu_issue_ctrl_if.sv
// idu_issue_ctrl_if: IFU/EXU/WBU handshake bundle of the issue controller.
interface idu_issue_ctrl_if #(parameter int INFL_W = 3);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic              in_use_rs1;
  logic              in_use_rs2;
  logic              in_gpr_wen;
  logic              in_serial;
  logic              hold_en;
  logic              out_valid;
  logic              out_ready;
  logic              wb_retire;
  logic              wb_gpr_wen;
  logic [4:0]        wb_rd;
  logic              flush;
  logic [1:0]        stall_cause;
  logic [INFL_W-1:0] inflight;
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_gpr_wen, in_serial,
    output out_ready, wb_retire, wb_gpr_wen, wb_rd, flush,
    input  in_ready, hold_en, out_valid, stall_cause, inflight
  );
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2, in_gpr_wen, in_serial,
    input  out_ready, wb_retire, wb_gpr_wen, wb_rd, flush,
    output in_ready, hold_en, out_valid, stall_cause, inflight
  );
endinterface

// File: rtl/idu_scoreboard.sv
// idu_scoreboard: per-GPR pending-write counters with two source read ports and an rd-at-max flag.
module idu_scoreboard #(
  parameter int NREG = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [4:0]       inc_idx,
  input  logic             dec,
  input  logic [4:0]       dec_idx,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  output logic [CNT_W-1:0] cnt_rs1,
  output logic [CNT_W-1:0] cnt_rs2,
  output logic             rd_max
);
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  up, dn;
  always_comb begin
    up = '0;
    dn = '0;
    for (int k = 1; k < NREG; k++) begin
      up[k] = inc && inc_idx == 5'(k);
      dn[k] = dec && dec_idx == 5'(k);
    end
  end
  // x0 never sees up/dn, so it stays at its reset value of zero
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      cnt <= '{default: '0};
    else
      for (int k = 0; k < NREG; k++)
        if (up[k] && !dn[k])
          cnt[k] <= cnt[k] + 1'b1;
        else if (dn[k] && !up[k] && cnt[k] != '0)
          cnt[k] <= cnt[k] - 1'b1;
  assign cnt_rs1 = cnt[rs1];
  assign cnt_rs2 = cnt[rs2];
  assign rd_max = cnt[rd] == '1;
  assert property (@(posedge clk) disable iff (!reset)
    dec && dec_idx != '0 && !(inc && inc_idx == dec_idx) |-> cnt[dec_idx] != '0);
endmodule

// File: rtl/idu_issue_ctrl.sv
// idu_issue_ctrl: decode-stage issue controller with RAW scoreboard and serialisation;
// define IDU_ISSUE_FWD_EN to let same-cycle write-back release dependent/serial instructions.
module idu_issue_ctrl
  import idu_issue_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int CNT_W = CNT_W_D,
  parameter int INFL_W = INFL_W_D
) (
  input logic             clk,
  input logic             reset,
  idu_issue_ctrl_if.slave io
);
  state_e            state, state_nx;
  instr_t            held;
  logic [INFL_W-1:0] infl;
  logic [CNT_W-1:0]  cnt_rs1, cnt_rs2;
  logic              rd_max, fire, raw, ser, cap, fwd1, fwd2, fwd_ser;
  idu_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .inc     (fire && held.gpr_wen && held.rd != '0),
    .inc_idx (held.rd),
    .dec     (io.wb_retire && io.wb_gpr_wen && io.wb_rd != '0),
    .dec_idx (io.wb_rd),
    .rs1     (held.rs1),
    .rs2     (held.rs2),
    .rd      (held.rd),
    .cnt_rs1 (cnt_rs1),
    .cnt_rs2 (cnt_rs2),
    .rd_max  (rd_max)
  );
`ifdef IDU_ISSUE_FWD_EN
  assign fwd1 = cnt_rs1 == CNT_W'(1) && io.wb_retire && io.wb_gpr_wen && io.wb_rd == held.rs1;
  assign fwd2 = cnt_rs2 == CNT_W'(1) && io.wb_retire && io.wb_gpr_wen && io.wb_rd == held.rs2;
  assign fwd_ser = infl == INFL_W'(1) && io.wb_retire;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
  assign fwd_ser = 1'b0;
`endif
  always_comb begin
    raw = (held.use_rs1 && held.rs1 != '0 && cnt_rs1 != '0 && !fwd1) ||
          (held.use_rs2 && held.rs2 != '0 && cnt_rs2 != '0 && !fwd2);
    ser = held.serial && infl != '0 && !fwd_ser;
    cap = infl == '1 || (held.gpr_wen && held.rd != '0 && rd_max);
    io.out_valid = state == HELD && !(raw || ser || cap) && !io.flush;
    fire = io.out_valid && io.out_ready;
    io.in_ready = !io.flush && (state == EMPTY || fire);
    io.hold_en = io.in_valid && io.in_ready;
    io.stall_cause = state != HELD ? SC_NONE : raw ? SC_RAW : ser ? SC_SERIAL : cap ? SC_CAP : SC_NONE;
    io.inflight = infl;
    state_nx = io.flush ? EMPTY : io.hold_en ? HELD : fire ? EMPTY : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= EMPTY;
      held <= '0;
      infl <= '0;
    end else begin
      state <= state_nx;
      if (io.hold_en)
        held <= '{rs1: io.in_rs1, rs2: io.in_rs2, rd: io.in_rd, use_rs1: io.in_use_rs1,
                  use_rs2: io.in_use_rs2, gpr_wen: io.in_gpr_wen, serial: io.in_serial};
      infl <= (fire && !io.wb_retire) ? infl + 1'b1 :
              (io.wb_retire && !fire && infl != '0) ? infl - 1'b1 : infl;
    end
  assert property (@(posedge clk) disable iff (!reset) io.wb_retire && !fire |-> infl != '0);
endmodule

// File: tb/tb_idu_issue_ctrl.sv
// tb_idu_issue_ctrl: directed scoreboard bench for idu_issue_ctrl (honours IDU_ISSUE_FWD_EN).
module tb_idu_issue_ctrl;
  typedef struct {
    logic       ir;
    logic       ov;
    logic       he;
    logic [1:0] sc;
    int         inf;
    int         ci;
    int         cv;
  } exp_t;
  logic   clk = 1'b0;
  logic   reset = 1'b0;
  exp_t   q_exp[$];
  string  q_name[$];
  int     checks = 0;
  int     errors = 0;
  idu_issue_ctrl_if #(.INFL_W(3)) io ();
  idu_issue_ctrl dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s.%s got=%0d want=%0d", n, f, act, want);
    end
  endtask
  // monitor: one expectation per cycle, compared mid-cycle
  always @(negedge clk)
    if (q_exp.size() > 0) begin
      exp_t e;
      string n;
      e = q_exp.pop_front();
      n = q_name.pop_front();
      chk(n, "in_ready", int'(io.in_ready), int'(e.ir));
      chk(n, "out_valid", int'(io.out_valid), int'(e.ov));
      chk(n, "hold_en", int'(io.hold_en), int'(e.he));
      chk(n, "stall_cause", int'(io.stall_cause), int'(e.sc));
      chk(n, "inflight", int'(io.inflight), e.inf);
      if (e.ci >= 0) chk(n, "cnt", int'(dut.u_sb.cnt[e.ci]), e.cv);
    end
  task automatic ins(input logic v, input logic [4:0] rs1, rs2, rd,
                     input logic u1, u2, wen, ser);
    io.in_valid = v;
    io.in_rs1 = rs1;
    io.in_rs2 = rs2;
    io.in_rd = rd;
    io.in_use_rs1 = u1;
    io.in_use_rs2 = u2;
    io.in_gpr_wen = wen;
    io.in_serial = ser;
  endtask
  task automatic wb(input logic r, input logic [4:0] rd);
    io.wb_retire = r;
    io.wb_gpr_wen = r;
    io.wb_rd = rd;
  endtask
  task automatic step(input string n, input logic ir, ov, he, input logic [1:0] sc,
                      input int inf, input int ci = -1, input int cv = 0);
    exp_t e;
    e = '{ir: ir, ov: ov, he: he, sc: sc, inf: inf, ci: ci, cv: cv};
    q_exp.push_back(e);
    q_name.push_back(n);
    @(posedge clk);
    #1;
  endtask
  initial begin
    ins(1, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0);
    io.out_ready = 1'b1;
    io.flush = 1'b0;
    @(posedge clk);
    #1;
    step("rst_hold", 1, 0, 1, 0, 0);
    reset = 1'b1;
    // reset while a RAW-stalled instruction is held
    ins(1, 0, 0, 5, 1, 0, 1, 0);     step("t1_acc", 1, 0, 1, 0, 0);
    ins(1, 5, 5, 6, 1, 1, 1, 0);     step("t1_fire", 1, 1, 1, 0, 0);
    ins(0, 0, 0, 0, 0, 0, 0, 0);     step("t1_raw", 0, 0, 0, 1, 1, 5, 1);
    reset = 1'b0;                    step("t1_rst", 1, 0, 0, 0, 0, 5, 0);
    reset = 1'b1;                    step("t1_post", 1, 0, 0, 0, 0, 5, 0);
    // RAW stall released by write-back of x5
    ins(1, 0, 0, 5, 1, 0, 1, 0);     step("t2_acc", 1, 0, 1, 0, 0);
    ins(1, 5, 5, 6, 1, 1, 1, 0);     step("t2_f0", 1, 1, 1, 0, 0, 5, 0);
    ins(0, 0, 0, 0, 0, 0, 0, 0);     step("t2_raw", 0, 0, 0, 1, 1, 5, 1);
    wb(1, 5);
`ifdef IDU_ISSUE_FWD_EN
    step("t2_fwd", 1, 1, 0, 0, 1, 5, 1);
    wb(0, 0);                        step("t2_empty", 1, 0, 0, 0, 1, 5, 0);
`else
    step("t2_raw2", 0, 0, 0, 1, 1, 5, 1);
    wb(0, 0);                        step("t2_fire", 1, 1, 0, 0, 0, 5, 0);
`endif
    wb(1, 6);                        step("t2_post", 1, 0, 0, 0, 1, 6, 1);
    wb(0, 0);                        step("t2_done", 1, 0, 0, 0, 0, 6, 0);
    // back-to-back stream of independent instructions
    ins(1, 0, 0, 10, 1, 0, 1, 0);    step("t3_acc", 1, 0, 1, 0, 0);
    ins(1, 0, 0, 11, 1, 0, 1, 0);    step("t3_f0", 1, 1, 1, 0, 0);
    ins(1, 0, 0, 12, 1, 0, 1, 0);    step("t3_f1", 1, 1, 1, 0, 1);
    ins(1, 0, 0, 13, 1, 0, 1, 0);    step("t3_f2", 1, 1, 1, 0, 2);
    ins(0, 0, 0, 0, 0, 0, 0, 0);     step("t3_f3", 1, 1, 0, 0, 3);
    wb(1, 10);                       step("t3_r0", 1, 0, 0, 0, 4, 10, 1);
    for (int i = 1; i < 4; i++) begin
      wb(1, 5'(10 + i));
      step("t3_r", 1, 0, 0, 0, 4 - i, 10 + i, 1);
    end
    wb(0, 0);                        step("t3_done", 1, 0, 0, 0, 0, 13, 0);
    // serialising instruction waits for an empty pipe
    ins(1, 0, 0, 14, 0, 0, 1, 0);    step("t4_acc", 1, 0, 1, 0, 0);
    ins(1, 0, 0, 15, 0, 0, 1, 0);    step("t4_f0", 1, 1, 1, 0, 0);
    ins(1, 0, 0, 16, 0, 0, 1, 1);    step("t4_f1", 1, 1, 1, 0, 1);
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 14);                       step("t4_ser", 0, 0, 0, 2, 2);
    wb(1, 15);
`ifdef IDU_ISSUE_FWD_EN
    step("t4_fwd", 1, 1, 0, 0, 1);
    wb(0, 0);                        step("t4_empty", 1, 0, 0, 0, 1);
`else
    step("t4_ser1", 0, 0, 0, 2, 1);
    wb(0, 0);                        step("t4_fire", 1, 1, 0, 0, 0);
`endif
    wb(1, 16);                       step("t4_post", 1, 0, 0, 0, 1, 16, 1);
    wb(0, 0);                        step("t4_done", 1, 0, 0, 0, 0, 16, 0);
    // per-register capacity on x7
    ins(1, 0, 0, 7, 0, 0, 1, 0);     step("t5_acc", 1, 0, 1, 0, 0);
    step("t5_f0", 1, 1, 1, 0, 0);
    step("t5_f1", 1, 1, 1, 0, 1);
    step("t5_f2", 1, 1, 1, 0, 2, 7, 2);
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 7);                        step("t5_cap", 0, 0, 0, 3, 3, 7, 3);
    wb(0, 0);                        step("t5_fire", 1, 1, 0, 0, 2, 7, 2);
    wb(1, 7);                        step("t5_r0", 1, 0, 0, 0, 3, 7, 3);
    step("t5_r1", 1, 0, 0, 0, 2, 7, 2);
    step("t5_r2", 1, 0, 0, 0, 1, 7, 1);
    wb(0, 0);                        step("t5_done", 1, 0, 0, 0, 0, 7, 0);
    // flush drops the held instruction; issue and retire of x9 in one cycle
    ins(1, 0, 0, 9, 0, 0, 1, 0);     step("t6_acc", 1, 0, 1, 0, 0);
    io.flush = 1'b1;                 step("t6_flush", 0, 0, 0, 0, 0, 9, 0);
    io.flush = 1'b0;                 step("t6_acc2", 1, 0, 1, 0, 0, 9, 0);
    step("t6_f0", 1, 1, 1, 0, 0);
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 9);                        step("t6_f1", 1, 1, 0, 0, 1, 9, 1);
    step("t6_same", 1, 0, 0, 0, 1, 9, 1);
    wb(0, 0);                        step("t6_done", 1, 0, 0, 0, 0, 9, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
